// File: rtl/axi_rd_responder_if.sv
// AR/R channel bundle between a read initiator and the responder.
// slave is the responder side, master the initiator side.
interface axi_rd_responder_if #(
    parameter int ADDR_BITS            = 64,
    parameter int BURST_LEN_WIDTH      = 8,
    parameter int TID_WIDTH            = 8,
    parameter int LOG_BLOCK_DATA_BYTES = 0
);
    localparam int DATA_WIDTH = 8 << LOG_BLOCK_DATA_BYTES;

    logic                       s_ar_valid;
    logic                       s_ar_ready;
    logic [ADDR_BITS-1:0]       s_ar_addr;
    logic [BURST_LEN_WIDTH-1:0] s_ar_len;
    logic [TID_WIDTH-1:0]       s_ar_id;
    logic                       s_r_valid;
    logic                       s_r_ready;
    logic [DATA_WIDTH-1:0]      s_r_data;
    logic                       s_r_last;
    logic [TID_WIDTH-1:0]       s_r_id;

    modport slave (
        input  s_ar_valid, s_ar_addr, s_ar_len, s_ar_id, s_r_ready,
        output s_ar_ready, s_r_valid, s_r_data, s_r_last, s_r_id
    );

    modport master (
        output s_ar_valid, s_ar_addr, s_ar_len, s_ar_id, s_r_ready,
        input  s_ar_ready, s_r_valid, s_r_data, s_r_last, s_r_id
    );
endinterface

// File: rtl/axi_rd_responder.sv
// In-order AXI-style read responder: queues AR requests, returns address-pattern bursts.
// First beat rd_latency+2 cycles after AR; R stalls hold the beat, AR ready drops when the queue is full.
module axi_rd_responder #(
    parameter int ADDR_BITS            = 64,
    parameter int BURST_LEN_WIDTH      = 8,
    parameter int TID_WIDTH            = 8,
    parameter int LOG_BLOCK_DATA_BYTES = 0,
    parameter int LOG_QUEUE_SIZE       = 3,
    parameter int LATENCY_WIDTH        = 8
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     en,
    input  logic [LATENCY_WIDTH-1:0] rd_latency,
    axi_rd_responder_if.slave        bus,
    output logic [LOG_QUEUE_SIZE:0]  outstandingCnt
);
    localparam int DATA_WIDTH = 8 << LOG_BLOCK_DATA_BYTES;
    localparam int DEPTH      = 1 << LOG_QUEUE_SIZE;
    localparam int PTR_W      = (LOG_QUEUE_SIZE > 0) ? LOG_QUEUE_SIZE : 1;

    typedef struct packed {
        logic [ADDR_BITS-1:0]       addr;
        logic [BURST_LEN_WIDTH-1:0] len;
        logic [TID_WIDTH-1:0]       id;
    } req_t;

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    state_t                     state, state_nxt;
    req_t                       queue [DEPTH];
    req_t                       active;
    logic [PTR_W-1:0]           wr_ptr, rd_ptr;
    logic [LOG_QUEUE_SIZE:0]    count;
    logic [LATENCY_WIDTH-1:0]   lat_cnt;
    logic [BURST_LEN_WIDTH-1:0] beat;
    logic [ADDR_BITS-1:0]       beat_addr;
    logic [LOG_QUEUE_SIZE+1:0]  occ_sum;
    logic                       full, empty, push, pop, beat_last;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full           = (count == (LOG_QUEUE_SIZE+1)'(DEPTH));
    assign empty          = (count == '0);
    assign bus.s_ar_ready = en && !full;
    assign push           = bus.s_ar_valid && bus.s_ar_ready;
    assign beat_addr      = active.addr + (ADDR_BITS'(beat) << LOG_BLOCK_DATA_BYTES);
    assign beat_last      = (beat == active.len);

    // Occupancy plus the burst in flight; the extra bit absorbs the +1 before saturation.
    assign occ_sum        = {1'b0, count} + {{(LOG_QUEUE_SIZE+1){1'b0}}, state != IDLE};
    assign outstandingCnt = occ_sum[LOG_QUEUE_SIZE+1] ? '1 : occ_sum[LOG_QUEUE_SIZE:0];

    always_comb begin
        state_nxt     = state;
        pop           = 1'b0;
        bus.s_r_valid = 1'b0;
        bus.s_r_last  = 1'b0;
        bus.s_r_data  = '0;
        bus.s_r_id    = '0;
        case (state)
            IDLE: begin
                if (en && !empty) begin
                    pop       = 1'b1;
                    state_nxt = (rd_latency != '0) ? WAIT : BURST;
                end
            end
            WAIT: begin
                if (en && lat_cnt == LATENCY_WIDTH'(1)) state_nxt = BURST;
            end
            BURST: begin
                bus.s_r_valid = 1'b1;
                bus.s_r_last  = beat_last;
                bus.s_r_data  = beat_addr[DATA_WIDTH-1:0];
                bus.s_r_id    = active.id;
                if (bus.s_r_ready && beat_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            lat_cnt <= '0;
            beat    <= '0;
            active  <= '0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop) begin
                rd_ptr  <= ptr_inc(rd_ptr);
                active  <= queue[rd_ptr];
                lat_cnt <= rd_latency;
                beat    <= '0;
            end else if (state == WAIT && en) begin
                lat_cnt <= lat_cnt - 1'b1;
            end else if (state == BURST && bus.s_r_ready) begin
                beat <= beat + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) queue[wr_ptr] <= '{addr: bus.s_ar_addr, len: bus.s_ar_len, id: bus.s_ar_id};
    end
endmodule

// File: tb/tb_axi_rd_responder.sv
// Bench for axi_rd_responder: directed latency/stall/full/wrap/reset cases plus random traffic vs a beat scoreboard.
module tb_axi_rd_responder;
    localparam int LOG   = 0;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [7:0] id;
    } beat_t;

    logic       clk = 1'b0;
    logic       resetN;
    logic       en;
    logic [7:0] rd_latency;
    logic [3:0] outstandingCnt;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    outstanding = 0;
    bit    hold_pend = 0;
    beat_t held;
    beat_t expq[$];
    int    rdy21[6] = '{1, 0, 0, 1, 1, 1};
    int    dat21[6] = '{'h10, 'h11, 'h11, 'h11, 'h12, 'h13};

    axi_rd_responder_if #(.ADDR_BITS(64), .BURST_LEN_WIDTH(8), .TID_WIDTH(8),
                          .LOG_BLOCK_DATA_BYTES(LOG)) bus ();

    axi_rd_responder #(
        .ADDR_BITS(64), .BURST_LEN_WIDTH(8), .TID_WIDTH(8),
        .LOG_BLOCK_DATA_BYTES(LOG), .LOG_QUEUE_SIZE(3), .LATENCY_WIDTH(8)
    ) dut (
        .clk(clk), .resetN(resetN), .en(en), .rd_latency(rd_latency),
        .bus(bus), .outstandingCnt(outstandingCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Scoreboard: every accepted request expands to its beats, returned strictly in acceptance order.
    always @(negedge clk) begin
        if (!resetN) begin
            expq.delete();
            outstanding = 0;
            hold_pend   = 0;
        end else begin
            if (!en) chk("ar_rdy_dis", bus.s_ar_ready, 0);
            else if (outstanding < DEPTH) chk("ar_rdy", bus.s_ar_ready, 1);
            else if (outstanding == DEPTH + 1) chk("ar_full", bus.s_ar_ready, 0);
            chk("outst", outstandingCnt, outstanding);
            if (hold_pend) begin
                chk("r_hold_vld", bus.s_r_valid, 1);
                chk("r_hold_beat", {bus.s_r_data, bus.s_r_last, bus.s_r_id}, held);
            end
            if (bus.s_r_valid) begin
                if (expq.size() == 0) begin
                    chk("r_spurious", bus.s_r_valid, 0);
                end else begin
                    chk("r_data", bus.s_r_data, expq[0].data);
                    chk("r_last", bus.s_r_last, expq[0].last);
                    chk("r_id", bus.s_r_id, expq[0].id);
                    if (bus.s_r_ready) begin
                        if (expq[0].last) outstanding--;
                        void'(expq.pop_front());
                    end
                end
                hold_pend = !bus.s_r_ready;
                held      = {bus.s_r_data, bus.s_r_last, bus.s_r_id};
            end else begin
                chk("r_idle_out", {bus.s_r_data, bus.s_r_last, bus.s_r_id}, 0);
                hold_pend = 0;
            end
            if (bus.s_ar_valid && bus.s_ar_ready) begin
                for (int b = 0; b <= int'(bus.s_ar_len); b++) begin
                    logic [63:0] a;
                    a = bus.s_ar_addr + (64'(b) << LOG);
                    expq.push_back('{data: a[7:0], last: (b == int'(bus.s_ar_len)), id: bus.s_ar_id});
                end
                outstanding++;
            end
        end
    end

    task automatic send(input logic [63:0] a, input logic [7:0] l, input logic [7:0] i);
        bus.s_ar_valid = 1'b1;
        bus.s_ar_addr  = a;
        bus.s_ar_len   = l;
        bus.s_ar_id    = i;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        en = 1'b0;
        rd_latency = '0;
        bus.s_ar_valid = 1'b0;
        bus.s_ar_addr = '0;
        bus.s_ar_len = '0;
        bus.s_ar_id = '0;
        bus.s_r_ready = 1'b0;
        #1;
        chk("rst_vld", bus.s_r_valid, 0);
        chk("rst_last", bus.s_r_last, 0);
        chk("rst_data", bus.s_r_data, 0);
        chk("rst_id", bus.s_r_id, 0);
        chk("rst_outst", outstandingCnt, 0);
        chk("rst_rdy_off", bus.s_ar_ready, 0);
        en = 1'b1;
        #1;
        chk("rst_rdy_on", bus.s_ar_ready, 1);
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;
    endtask

    task automatic drain(input string tag);
        bus.s_ar_valid = 1'b0;
        bus.s_r_ready  = 1'b1;
        en = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (outstandingCnt == 0 && expq.size() == 0) break;
        end
        #1;
        chk({tag, "_outst"}, outstandingCnt, 0);
        chk({tag, "_sb"}, 64'(expq.size()), 0);
    endtask

    initial begin
        // Single beat, latency 3: handshake in cycle 0, beat in cycle 5.
        do_reset();
        rd_latency = 8'd3;
        bus.s_r_ready = 1'b1;
        @(posedge clk); #1;
        send(64'hdeadbeef, 8'd0, 8'd5);
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            bus.s_ar_valid = 1'b0;
            #1;
            chk("lat3_vld", bus.s_r_valid, k == 5);
            if (k == 5) begin
                chk("lat3_data", bus.s_r_data, 8'hef);
                chk("lat3_last", bus.s_r_last, 1);
                chk("lat3_id", bus.s_r_id, 5);
            end
        end
        chk("lat3_outst", outstandingCnt, 0);

        // Four-beat burst, zero latency, consecutive beats.
        do_reset();
        bus.s_r_ready = 1'b1;
        @(posedge clk); #1;
        send(64'h10, 8'd3, 8'd2);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            bus.s_ar_valid = 1'b0;
            #1;
            chk("b4_vld", bus.s_r_valid, (k >= 2 && k <= 5));
            if (k >= 2 && k <= 5) begin
                chk("b4_data", bus.s_r_data, 64'('h10 + k - 2));
                chk("b4_last", bus.s_r_last, k == 5);
            end
        end

        // Same burst with two stall cycles after the first beat.
        do_reset();
        @(posedge clk); #1;
        send(64'h10, 8'd3, 8'd2);
        bus.s_r_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            bus.s_ar_valid = 1'b0;
            bus.s_r_ready = (k >= 2 && k <= 7) ? rdy21[k-2][0] : 1'b1;
            #1;
            chk("stall_vld", bus.s_r_valid, (k >= 2 && k <= 7));
            if (k >= 2 && k <= 7) chk("stall_data", bus.s_r_data, 64'(dat21[k-2]));
        end

        // Fill the queue with R stalled: 9 accepted, 10th refused, ids drained in order.
        do_reset();
        rd_latency = 8'd1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            send({$urandom, $urandom}, 8'd0, 8'(i));
            #1;
            chk("full_rdy", bus.s_ar_ready, i < 9);
        end
        chk("full_outst", outstandingCnt, 9);
        drain("full_drain");

        // Address wrap at the top of the 64-bit space.
        do_reset();
        bus.s_r_ready = 1'b1;
        @(posedge clk); #1;
        send(64'hffffffffffffffff, 8'd1, 8'd7);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            bus.s_ar_valid = 1'b0;
            #1;
            if (k == 2) chk("wrap_b0", bus.s_r_data, 8'hff);
            if (k == 3) chk("wrap_b1", {bus.s_r_data, bus.s_r_last}, {8'h00, 1'b1});
        end

        // Reset during beat 2 of an eight-beat burst.
        do_reset();
        bus.s_r_ready = 1'b1;
        @(posedge clk); #1;
        send(64'h40, 8'd7, 8'd3);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            bus.s_ar_valid = 1'b0;
        end
        #1;
        chk("mid_beat2", bus.s_r_data, 8'h42);
        do_reset();
        bus.s_r_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1; #1;
            chk("post_rst_idle", bus.s_r_valid, 0);
        end
        @(posedge clk); #1;
        send(64'h80, 8'd0, 8'd9);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            bus.s_ar_valid = 1'b0;
            #1;
            chk("fresh_vld", bus.s_r_valid, k == 2);
        end

        // Random traffic with enable, latency and R backpressure all varying.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            en = ($urandom_range(7) != 0);
            rd_latency = 8'($urandom_range(3));
            bus.s_r_ready = ($urandom_range(3) != 0);
            if ($urandom_range(1) != 0) send({$urandom, $urandom}, 8'($urandom_range(3)), 8'($urandom_range(255)));
            else bus.s_ar_valid = 1'b0;
        end
        drain("rand_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axi_rd_responder.md
AXI_RD_RESPONDER -- requirements
Module: axi_rd_responder

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
 ADDR_BITS, 64, AR address width.
 BURST_LEN_WIDTH, 8, AR len width; beats = len+1.
 TID_WIDTH, 8, transaction ID width.
 LOG_BLOCK_DATA_BYTES, 0, log2 bytes per beat; DATA_WIDTH = 8<<LOG_BLOCK_DATA_BYTES.
 LOG_QUEUE_SIZE, 3, log2 depth of request queue.
 LATENCY_WIDTH, 8, width of rd_latency.
REQ-002 Ports SHALL be (name, direction, width, meaning):
 clk, in, 1, the single clock.
 resetN, in, 1, reset, asynchronous and active-low.
 en, in, 1, global enable.
 rd_latency, in, LATENCY_WIDTH, idle cycles inserted before each burst.
 s_ar_valid, in, 1, read request valid.
 s_ar_ready, out, 1, request accepted.
 s_ar_addr, in, ADDR_BITS, burst start address.
 s_ar_len, in, BURST_LEN_WIDTH, burst length minus one.
 s_ar_id, in, TID_WIDTH, request ID.
 s_r_valid, out, 1, read beat valid.
 s_r_ready, in, 1, initiator accepts beat.
 s_r_data, out, DATA_WIDTH, beat data.
 s_r_last, out, 1, final beat of burst.
 s_r_id, out, TID_WIDTH, ID of burst being returned.
 outstandingCnt, out, LOG_QUEUE_SIZE+1, requests accepted and not fully returned (queued plus active).

Function
REQ-003 Requests SHALL be stored in an in-order FIFO of 2^LOG_QUEUE_SIZE entries of {addr, len, id}; push on s_ar_valid && s_ar_ready.
REQ-004 s_ar_ready SHALL be combinational: en && !fifoFull; it SHALL not depend on s_ar_valid.
REQ-005 FSM states: IDLE, WAIT, BURST.
REQ-006 IDLE: if en && FIFO non-empty, pop head into active registers, load latency counter with rd_latency, beat counter to 0; go WAIT if rd_latency != 0, else BURST.
REQ-007 WAIT: if en, decrement counter; when counter == 1 at the edge, go BURST; if !en, hold counter and state.
REQ-008 Latency SHALL be exact: AR handshake in cycle 0 into an empty idle block -> first s_r_valid in cycle rd_latency+2.
REQ-009 BURST: s_r_valid = 1; s_r_id = active id; s_r_data = low DATA_WIDTH bits of (addr + (beat << LOG_BLOCK_DATA_BYTES)) mod 2^ADDR_BITS; s_r_last = (beat == len).
REQ-010 Beat advances only on s_r_valid && s_r_ready; while s_r_valid && !s_r_ready, data/last/id SHALL be held stable.
REQ-011 On handshake of last beat: go IDLE; if FIFO non-empty and en, the next burst starts per REQ-006 (one idle cycle between bursts minimum).
REQ-012 en = 0 SHALL not truncate BURST; an active burst drains normally.
REQ-013 Simultaneous push and pop in one cycle SHALL be legal; push when full SHALL not occur (ready low); FIFO pointers wrap modulo depth.
REQ-014 outstandingCnt SHALL be FIFO occupancy + (state != IDLE); max value 2^LOG_QUEUE_SIZE+1 clipped by width, so width SHALL hold 2^LOG_QUEUE_SIZE+1 (use LOG_QUEUE_SIZE+2 if needed internally, output saturated).
REQ-015 Responses SHALL be returned strictly in acceptance order regardless of ID.
REQ-016 Outside BURST: s_r_valid = 0, s_r_last = 0, s_r_data and s_r_id = 0.

Reset
REQ-017 resetN low SHALL immediately (asynchronously) clear FIFO pointers, counters, active registers, state to IDLE; s_r_valid, s_r_last, s_r_data, s_r_id, outstandingCnt = 0; s_ar_ready = en after reset.
REQ-018 Reset mid-burst SHALL abandon the burst with no further beats; first request after release is treated as fresh.

Verification
REQ-019 rd_latency=3, AR addr 0xdeadbeef len 0 id 5, s_r_ready=1 -> single beat in cycle 5, data 0xef, last 1, id 5; outstandingCnt returns to 0.
REQ-020 rd_latency=0, AR addr 0x10 len 3 id 2 -> beats 0x10,0x11,0x12,0x13 on consecutive cycles, last only on 0x13.
REQ-021 Same burst with s_r_ready low 2 cycles after first beat -> 0x11 held 3 cycles, no beat lost or duplicated.
REQ-022 s_r_ready=0, 10 back-to-back ARs, LOG_QUEUE_SIZE=3 -> 9 accepted (8 queued + 1 active), s_ar_ready=0 on 10th, outstandingCnt=9; then ids returned in order.
REQ-023 AR addr 0xffffffffffffffff len 1 -> data 0xff then 0x00 (address wrap).
REQ-024 resetN pulsed low during beat 2 of len-7 burst -> s_r_valid drops same cycle, outstandingCnt=0, queue empty after release.
